// File: rtl/cpld_rx_if.sv
// -----------------------------------------------------------------------------
// cpld_rx_if
// Groups the FPGA-to-CPLD LED/7-segment link pins and the display-side results
// of the CPLD receiver.
//   cpld_clk, cpld_ld, cpld_mosi : serial link (driven by the FPGA side)
//   led[7:0]                     : discrete LED drive, active-high
//   seg[7:0]                     : segment drive, low = segment lit, bit 7 = dp
//   dig_en[1:0]                  : one-hot digit enable
//   frame_ok                     : one-cycle pulse per committed frame
//   frame_err                    : sticky bad-length frame flag
// Modports: master = link driver / display consumer, slave = receiver.
// -----------------------------------------------------------------------------
interface cpld_rx_if;
   logic       cpld_clk;
   logic       cpld_ld;
   logic       cpld_mosi;
   logic [7:0] led;
   logic [7:0] seg;
   logic [1:0] dig_en;
   logic       frame_ok;
   logic       frame_err;

   modport master (
      output cpld_clk, cpld_ld, cpld_mosi,
      input  led, seg, dig_en, frame_ok, frame_err
   );

   modport slave (
      input  cpld_clk, cpld_ld, cpld_mosi,
      output led, seg, dig_en, frame_ok, frame_err
   );
endinterface

// File: rtl/cpld_rx.sv
// -----------------------------------------------------------------------------
// cpld_rx
// CPLD-side receiver for the FPGA-to-CPLD LED/7-segment serial link. The three
// asynchronous link inputs are oversampled on clk, 16-bit LSB-first frames are
// assembled, and every good frame is committed to the LED outputs, the
// segment pattern and the alternating digit enable.
// Ports:
//   clk   : system clock, rising edge
//   rstn  : synchronous active-low reset
//   link  : cpld_rx_if.slave (link pins in, display outputs out)
// Parameter:
//   SYNC_STAGES : synchronizer depth per link input (>= 2)
// -----------------------------------------------------------------------------
module cpld_rx #(
   parameter int SYNC_STAGES = 2
) (
   input  logic   clk,
   input  logic   rstn,
   cpld_rx_if.slave link
);

   typedef enum logic [0:0] {
      WAIT_SYNC = 1'b0,
      RUN       = 1'b1
   } state_t;

   // Synchronizer chains and edge-detect history flops
   logic [SYNC_STAGES-1:0] clk_sync_q;
   logic [SYNC_STAGES-1:0] ld_sync_q;
   logic [SYNC_STAGES-1:0] mosi_sync_q;
   logic                   clk_hist_q;
   logic                   ld_hist_q;

   // Frame assembly and output state
   state_t      state_q,     state_d;
   logic [15:0] sr_q,        sr_d;
   logic [4:0]  bitcnt_q,    bitcnt_d;
   logic        next_dig_q,  next_dig_d;
   logic [7:0]  led_q,       led_d;
   logic [7:0]  seg_q,       seg_d;
   logic [1:0]  dig_en_q,    dig_en_d;
   logic        frame_ok_q,  frame_ok_d;
   logic        frame_err_q, frame_err_d;

   // Combinational helpers
   logic        clk_s;
   logic        ld_s;
   logic        mosi_s;
   logic        rise_s;
   logic        ld_fall_s;
   logic [4:0]  bitcnt_inc_s;
   logic [4:0]  count_now_s;
   logic [15:0] sr_now_s;

   // Synchronizer chains plus one history flop per edge-detected input
   always_ff @(posedge clk) begin
      if (!rstn) begin
         clk_sync_q  <= '0;
         ld_sync_q   <= '0;
         mosi_sync_q <= '0;
         clk_hist_q  <= 1'b0;
         ld_hist_q   <= 1'b0;
      end else begin
         clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0],  link.cpld_clk};
         ld_sync_q   <= {ld_sync_q[SYNC_STAGES-2:0],   link.cpld_ld};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], link.cpld_mosi};
         clk_hist_q  <= clk_sync_q[SYNC_STAGES-1];
         ld_hist_q   <= ld_sync_q[SYNC_STAGES-1];
      end
   end

   assign clk_s     = clk_sync_q[SYNC_STAGES-1];
   assign ld_s      = ld_sync_q[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
   assign rise_s    = clk_s & ~clk_hist_q;
   assign ld_fall_s = ld_hist_q & ~ld_s;

   assign bitcnt_inc_s = (bitcnt_q == 5'd31) ? 5'd31 : (bitcnt_q + 5'd1);

   // Shift/count values including a bit arriving in this same cycle, so a
   // serial-clock rise coinciding with the frame end still belongs to the frame.
   assign count_now_s = rise_s ? bitcnt_inc_s : bitcnt_q;
   assign sr_now_s    = rise_s ? {mosi_s, sr_q[15:1]} : sr_q;

   // State and output registers
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q     <= WAIT_SYNC;
         sr_q        <= 16'h0000;
         bitcnt_q    <= 5'd0;
         next_dig_q  <= 1'b0;
         led_q       <= 8'h00;
         seg_q       <= 8'hFF;
         dig_en_q    <= 2'b00;
         frame_ok_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         sr_q        <= sr_d;
         bitcnt_q    <= bitcnt_d;
         next_dig_q  <= next_dig_d;
         led_q       <= led_d;
         seg_q       <= seg_d;
         dig_en_q    <= dig_en_d;
         frame_ok_q  <= frame_ok_d;
         frame_err_q <= frame_err_d;
      end
   end

   // Next-state logic: shifting/counting always runs; frame end decides commit
   always_comb begin
      state_d     = state_q;
      sr_d        = sr_now_s;
      bitcnt_d    = count_now_s;
      next_dig_d  = next_dig_q;
      led_d       = led_q;
      seg_d       = seg_q;
      dig_en_d    = dig_en_q;
      frame_ok_d  = 1'b0;
      frame_err_d = frame_err_q;

      if (ld_fall_s) begin
         bitcnt_d = 5'd0;
         case (state_q)
            // First frame end after reset only aligns to the link
            WAIT_SYNC: begin
               state_d = RUN;
            end
            RUN: begin
               if (count_now_s == 5'd16) begin
                  led_d      = sr_now_s[7:0];
                  seg_d      = sr_now_s[15:8];
                  dig_en_d   = next_dig_q ? 2'b10 : 2'b01;
                  next_dig_d = ~next_dig_q;
                  frame_ok_d = 1'b1;
               end else begin
                  frame_err_d = 1'b1;
               end
            end
            default: begin
               state_d = WAIT_SYNC;
            end
         endcase
      end else begin
         state_d = state_q;
      end
   end

   assign link.led       = led_q;
   assign link.seg       = seg_q;
   assign link.dig_en    = dig_en_q;
   assign link.frame_ok  = frame_ok_q;
   assign link.frame_err = frame_err_q;

endmodule

// File: tb/tb_cpld_rx.sv
// -----------------------------------------------------------------------------
// tb_cpld_rx
// Self-checking bench for cpld_rx. Drives serial frames with randomized phase
// lengths and data, and compares the display outputs against a frame-level
// model (sync flag, digit toggle, sticky error) kept in the bench.
// -----------------------------------------------------------------------------
module tb_cpld_rx;

   logic clk  = 1'b0;
   logic rstn = 1'b0;

   always #5 clk = ~clk;

   cpld_rx_if ifc ();

   cpld_rx #(.SYNC_STAGES(2)) dut (
      .clk  (clk),
      .rstn (rstn),
      .link (ifc)
   );

   int n_cmp  = 0;
   int n_err  = 0;
   int ok_cnt = 0;
   int exp_ok = 0;

   // Frame-level reference model
   bit         m_sync;
   bit         m_next;
   logic [7:0] m_led;
   logic [7:0] m_seg;
   logic [1:0] m_dig;
   bit         m_err;

   // Count frame_ok pulses (read before the DUT updates on this edge)
   always @(posedge clk) begin
      if (ifc.frame_ok === 1'b1) ok_cnt++;
   end

   task automatic model_reset();
      m_sync = 1'b0;
      m_next = 1'b0;
      m_led  = 8'h00;
      m_seg  = 8'hFF;
      m_dig  = 2'b00;
      m_err  = 1'b0;
   endtask

   // Effect of one frame end carrying n serial bits (data LSB first)
   task automatic model_frame(input logic [31:0] d, input int n);
      if (!m_sync) begin
         m_sync = 1'b1;
      end else if (n == 16) begin
         m_led  = d[7:0];
         m_seg  = d[15:8];
         m_dig  = m_next ? 2'b10 : 2'b01;
         m_next = !m_next;
         exp_ok++;
      end else begin
         m_err = 1'b1;
      end
   endtask

   // Send n bits LSB first; with_ld frames the last bit period with cpld_ld.
   // simul makes the last serial-clock rise coincide with the cpld_ld fall.
   task automatic send_frame(input logic [31:0] d, input int n,
                             input bit with_ld, input bit simul);
      for (int i = 0; i < n; i++) begin
         ifc.cpld_mosi = d[i];
         if (with_ld && i == n - 1) ifc.cpld_ld = 1'b1;
         repeat ($urandom_range(3, 6)) @(negedge clk);
         if (simul && with_ld && i == n - 1) begin
            ifc.cpld_clk = 1'b1;
            ifc.cpld_ld  = 1'b0;
            repeat (4) @(negedge clk);
            ifc.cpld_clk = 1'b0;
         end else begin
            ifc.cpld_clk = 1'b1;
            repeat ($urandom_range(3, 6)) @(negedge clk);
            ifc.cpld_clk = 1'b0;
         end
      end
      if (with_ld) ifc.cpld_ld = 1'b0;
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      for (int i = 0; i < 4; i++) begin
         ifc.cpld_clk  = i[0];
         ifc.cpld_ld   = 1'($urandom_range(0, 1));
         ifc.cpld_mosi = 1'($urandom_range(0, 1));
         @(negedge clk);
      end
      model_reset();
      n_cmp++;
      if ({ifc.led, ifc.seg, ifc.dig_en, ifc.frame_ok, ifc.frame_err} !== {8'h00, 8'hFF, 2'b00, 1'b0, 1'b0}) begin
         n_err++;
         $display("FAIL reset_values: got led=%h seg=%h dig=%b ok=%b err=%b, required 00 ff 00 0 0",
                  ifc.led, ifc.seg, ifc.dig_en, ifc.frame_ok, ifc.frame_err);
      end
      ifc.cpld_clk  = 1'b0;
      ifc.cpld_ld   = 1'b0;
      ifc.cpld_mosi = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      repeat (4) @(negedge clk);
      n_cmp++;
      if (ok_cnt !== 0) begin
         n_err++;
         $display("FAIL reset_no_ok: got %0d frame_ok pulses, required 0", ok_cnt);
      end
   endtask

   task automatic test_sync_data();
      logic [31:0] d;
      d = $urandom;
      send_frame(d, 9, 1'b1, 1'b0);
      model_frame(d, 9);
      repeat (6) @(negedge clk);
      n_cmp++;
      if ({ifc.led, ifc.seg, ifc.dig_en, ifc.frame_err} !== {m_led, m_seg, m_dig, m_err}) begin
         n_err++;
         $display("FAIL sync_discard: got %h required %h",
                  {ifc.led, ifc.seg, ifc.dig_en, ifc.frame_err}, {m_led, m_seg, m_dig, m_err});
      end
      d = 32'h0000_86A5;
      send_frame(d, 16, 1'b1, 1'b0);
      model_frame(d, 16);
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({ifc.led, ifc.frame_ok} !== {8'h00, 1'b0}) begin
         n_err++;
         $display("FAIL latency_early: got led=%h ok=%b, required led=00 ok=0", ifc.led, ifc.frame_ok);
      end
      @(negedge clk);
      n_cmp++;
      if ({ifc.led, ifc.seg, ifc.dig_en, ifc.frame_ok} !== {8'hA5, 8'h86, 2'b01, 1'b1}) begin
         n_err++;
         $display("FAIL latency_commit: got led=%h seg=%h dig=%b ok=%b, required a5 86 01 1",
                  ifc.led, ifc.seg, ifc.dig_en, ifc.frame_ok);
      end
      @(negedge clk);
      n_cmp++;
      if (ifc.frame_ok !== 1'b0) begin
         n_err++;
         $display("FAIL ok_width: got frame_ok=%b two cycles after commit, required 0", ifc.frame_ok);
      end
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({ifc.frame_err, ok_cnt} !== {m_err, exp_ok}) begin
         n_err++;
         $display("FAIL sync_ok_count: got err=%b ok=%0d, required err=%b ok=%0d",
                  ifc.frame_err, ok_cnt, m_err, exp_ok);
      end
   endtask

   task automatic test_alternation();
      logic [31:0] frames [3];
      frames[0] = 32'h0000_00FF;
      frames[1] = 32'h0000_F900;
      frames[2] = 32'h0000_1234;
      for (int k = 0; k < 3; k++) begin
         send_frame(frames[k], 16, 1'b1, 1'b0);
         model_frame(frames[k], 16);
         repeat (6) @(negedge clk);
         n_cmp++;
         if ({ifc.led, ifc.seg, ifc.dig_en, ifc.frame_err} !== {m_led, m_seg, m_dig, m_err} || ok_cnt !== exp_ok) begin
            n_err++;
            $display("FAIL alternation[%0d]: got %h ok=%0d required %h ok=%0d", k,
                     {ifc.led, ifc.seg, ifc.dig_en, ifc.frame_err}, ok_cnt,
                     {m_led, m_seg, m_dig, m_err}, exp_ok);
         end
      end
   endtask

   // Bad-length frame followed by a good one
   task automatic test_bad_length(input int n);
      logic [31:0] d;
      for (int k = 0; k < 2; k++) begin
         d = $urandom;
         send_frame(d, (k == 0) ? n : 16, 1'b1, 1'b0);
         model_frame(d, (k == 0) ? n : 16);
         repeat (6) @(negedge clk);
         n_cmp++;
         if ({ifc.led, ifc.seg, ifc.dig_en, ifc.frame_err} !== {m_led, m_seg, m_dig, m_err} || ok_cnt !== exp_ok) begin
            n_err++;
            $display("FAIL bad_length_%0d[%0d]: got %h ok=%0d required %h ok=%0d", n, k,
                     {ifc.led, ifc.seg, ifc.dig_en, ifc.frame_err}, ok_cnt,
                     {m_led, m_seg, m_dig, m_err}, exp_ok);
         end
      end
   endtask

   task automatic test_simultaneous();
      logic [31:0] d;
      for (int k = 0; k < 2; k++) begin
         d = $urandom;
         send_frame(d, 16, 1'b1, 1'b1);
         model_frame(d, 16);
         repeat (6) @(negedge clk);
         n_cmp++;
         if ({ifc.led, ifc.seg, ifc.dig_en, ifc.frame_err} !== {m_led, m_seg, m_dig, m_err} || ok_cnt !== exp_ok) begin
            n_err++;
            $display("FAIL simultaneous[%0d]: got %h ok=%0d required %h ok=%0d", k,
                     {ifc.led, ifc.seg, ifc.dig_en, ifc.frame_err}, ok_cnt,
                     {m_led, m_seg, m_dig, m_err}, exp_ok);
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [31:0] d;
      d = $urandom;
      send_frame(d, 9, 1'b0, 1'b0);
      rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      model_reset();
      n_cmp++;
      if ({ifc.led, ifc.seg, ifc.dig_en, ifc.frame_ok, ifc.frame_err} !== {8'h00, 8'hFF, 2'b00, 1'b0, 1'b0}) begin
         n_err++;
         $display("FAIL reset_mid_frame: got led=%h seg=%h dig=%b ok=%b err=%b, required 00 ff 00 0 0",
                  ifc.led, ifc.seg, ifc.dig_en, ifc.frame_ok, ifc.frame_err);
      end
      repeat (4) @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         d = $urandom;
         send_frame(d, 16, 1'b1, 1'b0);
         model_frame(d, 16);
         repeat (6) @(negedge clk);
         n_cmp++;
         if ({ifc.led, ifc.seg, ifc.dig_en, ifc.frame_err} !== {m_led, m_seg, m_dig, m_err} || ok_cnt !== exp_ok) begin
            n_err++;
            $display("FAIL after_reset[%0d]: got %h ok=%0d required %h ok=%0d", k,
                     {ifc.led, ifc.seg, ifc.dig_en, ifc.frame_err}, ok_cnt,
                     {m_led, m_seg, m_dig, m_err}, exp_ok);
         end
      end
   endtask

   task automatic test_random();
      logic [31:0] d;
      int          n;
      int          r;
      for (int k = 0; k < 24; k++) begin
         d = $urandom;
         r = $urandom_range(0, 9);
         if (r < 7)       n = 16;
         else if (r == 7) n = 15;
         else if (r == 8) n = 17;
         else             n = $urandom_range(1, 20);
         send_frame(d, n, 1'b1, ($urandom_range(0, 3) == 0));
         model_frame(d, n);
         repeat (6) @(negedge clk);
         n_cmp++;
         if ({ifc.led, ifc.seg, ifc.dig_en, ifc.frame_err} !== {m_led, m_seg, m_dig, m_err} || ok_cnt !== exp_ok) begin
            n_err++;
            $display("FAIL random[%0d] n=%0d: got %h ok=%0d required %h ok=%0d", k, n,
                     {ifc.led, ifc.seg, ifc.dig_en, ifc.frame_err}, ok_cnt,
                     {m_led, m_seg, m_dig, m_err}, exp_ok);
         end
      end
   endtask

   initial begin
      ifc.cpld_clk  = 1'b0;
      ifc.cpld_ld   = 1'b0;
      ifc.cpld_mosi = 1'b0;
      model_reset();
      @(negedge clk);
      test_reset();
      test_sync_data();
      test_alternation();
      test_bad_length(15);
      test_bad_length(17);
      test_simultaneous();
      test_reset_mid_frame();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
